ahb_burst_master_seq: RTL
=========================

Name: ahb_burst_master_seq

Overview:
- Parametrised AHB master address-phase sequencer, the successor to the global AHB parameter set.
- Accepts one burst command at a time and drives HADDR/HTRANS/HBURST/HSIZE/HWRITE for it.
- Covers all eight HBURST encodings, all HSIZE values up to DATA_WIDTH, BUSY insertion, wrap addressing and 1KB-boundary handling.
- Sits between each master's traffic engine and the arbiter/interconnect; one instance per master (NO_OF_MASTERS).

Parameters:
ADDR_WIDTH, 32, HADDR width
DATA_WIDTH, 32, bus data width; the largest legal HSIZE is log2(DATA_WIDTH/8)
LEN_WIDTH, 10, width of cmd_len (beat count for undefined-length INCR)
BOUNDARY, 1024, address boundary in bytes that no burst may cross

Ports:
HCLK  in  1  clock
HRESET  in  1  synchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
cmd_addr  in  ADDR_WIDTH  start byte address
cmd_burst  in  3  HBURST encoding (SINGLE..INCR16)
cmd_size  in  3  HSIZE encoding
cmd_len  in  LEN_WIDTH  beats for INCR; 0 treated as 1; ignored for other bursts
cmd_write  in  1  write/read
beat_stall  in  1  request a BUSY before the next beat
HREADY  in  1  bus ready
HADDR  out  ADDR_WIDTH  address
HTRANS  out  2  IDLE/BUSY/NONSEQ/SEQ
HBURST  out  3  burst type
HSIZE  out  3  transfer size
HWRITE  out  1  direction
beat_idx  out  LEN_WIDTH  index of the beat currently in address phase
done  out  1  one-cycle pulse when the last beat's address phase completes
err  out  1  one-cycle pulse when an accepted command is rejected

Behaviour:
- All state changes occur on the HCLK rising edge.
- HRESET=1 forces the following outputs on the next edge:
  - HTRANS=IDLE, HADDR=0, HBURST=SINGLE, HSIZE=BYTE, HWRITE=0
  - beat_idx=0, done=0, err=0, cmd_ready=1
  - FSM=S_IDLE; this applies mid-burst too, and the remaining beats are dropped.
- FSM states: S_IDLE, S_ACTIVE, S_BUSY.
- cmd_ready=1 only in S_IDLE.

Command acceptance (handshake in S_IDLE):
- The command is validated in the same cycle. It is illegal if any of:
  - cmd_size > log2(DATA_WIDTH/8)
  - cmd_addr is not aligned to 2^cmd_size
  - the burst is fixed-length INCR4/8/16 and the last byte crosses a BOUNDARY line
- Illegal: err=1 next cycle, remain in S_IDLE, no transfer issued, done not pulsed.
- Legal: next cycle is S_ACTIVE with HTRANS=NONSEQ, HADDR=cmd_addr, beat_idx=0. HBURST/HSIZE/HWRITE are registered and held for the whole burst.
- Beat counts: SINGLE=1, WRAP4/INCR4=4, WRAP8/INCR8=8, WRAP16/INCR16=16, INCR=max(cmd_len,1).

In S_ACTIVE:
- Outputs are held while HREADY=0.
- When HREADY=1 and this is the last beat: done=1 next cycle, HTRANS=IDLE, go to S_IDLE.
- When HREADY=1 and it is not the last beat:
  - Compute the next address and increment beat_idx.
  - If beat_stall=1: go to S_BUSY with HTRANS=BUSY and HADDR=next address.
  - Otherwise: HTRANS=SEQ.

Next address (bytes b = 2^HSIZE):
- INCR*: HADDR+b.
- WRAP*: mask = beats*b-1; next = (HADDR & ~mask) | ((HADDR+b) & mask).
- Undefined-length INCR reaching a BOUNDARY line: the beat that starts at the new boundary is issued as NONSEQ instead of SEQ. This is the only NONSEQ inside a burst.

In S_BUSY:
- HADDR, beat_idx and HBURST are held.
- Exit to S_ACTIVE with HTRANS=SEQ only when beat_stall=0 and HREADY=1; otherwise stay in S_BUSY.
- beat_stall is ignored on the final beat (no BUSY after the last beat) and for SINGLE.

Other rules:
- done and err are never high in the same cycle.
- Arithmetic: addresses wrap modulo 2^ADDR_WIDTH. beat_idx saturates at 2^LEN_WIDTH-1 and never wraps.

Test Plan:
- WRAP4, HSIZE=WORD, addr 0x38, HREADY=1 always -> HADDR 0x38,0x3C,0x30,0x34; HTRANS NONSEQ,SEQ,SEQ,SEQ; done pulses on the cycle after beat 3.
- INCR8, HSIZE=HALF_WORD, addr 0x100; HREADY=0 for 2 cycles on beat 2 -> HADDR 0x100..0x10E in steps of 2; beat 2 address held for 3 cycles; 8 beats total.
- INCR, cmd_len=6, WORD, addr 0x3F8 -> 0x3F8 SEQ? no: 0x3F8 NONSEQ, 0x3FC SEQ, 0x400 NONSEQ, 0x404..0x40C SEQ; done after the 6th beat.
- INCR4, WORD, beat_stall=1 for 2 cycles after beat 1 -> HTRANS NONSEQ,SEQ,BUSY,BUSY,SEQ,SEQ; HADDR 0x8 held during both BUSY cycles.
- Illegal commands: HSIZE=3'b011 with DATA_WIDTH=32 -> err=1 and HTRANS stays IDLE; INCR16 WORD at addr 0x3F0 -> err=1; misaligned WORD at 0x2 -> err=1.
- HRESET asserted at beat 5 of WRAP16 -> next cycle HTRANS=IDLE, HADDR=0, cmd_ready=1, no done; a new SINGLE command afterwards completes normally.

Source files
------------

// File: rtl/ahb_burst_master_seq_if.sv
// Command and AHB address-phase signals between a traffic engine, the
// burst sequencer and the interconnect.
//   master : the sequencer side (takes commands and HREADY, drives the bus)
//   slave  : the traffic engine / interconnect side
interface ahb_burst_master_seq_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned LEN_WIDTH  = 10
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [2:0]            cmd_burst;
   logic [2:0]            cmd_size;
   logic [LEN_WIDTH-1:0]  cmd_len;
   logic                  cmd_write;
   logic                  beat_stall;
   logic                  HREADY;
   logic [ADDR_WIDTH-1:0] HADDR;
   logic [1:0]            HTRANS;
   logic [2:0]            HBURST;
   logic [2:0]            HSIZE;
   logic                  HWRITE;
   logic [LEN_WIDTH-1:0]  beat_idx;
   logic                  done;
   logic                  err;

   modport master (
      input  cmd_valid, cmd_addr, cmd_burst, cmd_size, cmd_len, cmd_write,
             beat_stall, HREADY,
      output cmd_ready, HADDR, HTRANS, HBURST, HSIZE, HWRITE, beat_idx,
             done, err
   );

   modport slave (
      output cmd_valid, cmd_addr, cmd_burst, cmd_size, cmd_len, cmd_write,
             beat_stall, HREADY,
      input  cmd_ready, HADDR, HTRANS, HBURST, HSIZE, HWRITE, beat_idx,
             done, err
   );
endinterface

// File: rtl/ahb_burst_master_seq.sv
// AHB master address-phase sequencer: takes one burst command at a time and
// walks HADDR/HTRANS through it, with BUSY insertion, wrap addressing and
// boundary handling.
// Ports:
//   HCLK   : clock
//   HRESET : synchronous active-high reset
//   bus    : command handshake, beat_stall, HREADY in; HADDR/HTRANS/HBURST/
//            HSIZE/HWRITE, beat_idx, done/err pulses and cmd_ready out
module ahb_burst_master_seq #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned LEN_WIDTH  = 10,
   parameter int unsigned BOUNDARY   = 1024
) (
   input  logic                   HCLK,
   input  logic                   HRESET,
   ahb_burst_master_seq_if.master bus
);
   localparam int unsigned MAX_SIZE = $clog2(DATA_WIDTH / 8);
   localparam int unsigned BND_W    = $clog2(BOUNDARY);
   localparam int unsigned AW1      = ADDR_WIDTH + 1;

   localparam logic [1:0] TR_IDLE   = 2'b00;
   localparam logic [1:0] TR_BUSY   = 2'b01;
   localparam logic [1:0] TR_NONSEQ = 2'b10;
   localparam logic [1:0] TR_SEQ    = 2'b11;

   localparam logic [2:0] BU_SINGLE = 3'd0;
   localparam logic [2:0] BU_INCR   = 3'd1;
   localparam logic [2:0] BU_WRAP4  = 3'd2;
   localparam logic [2:0] BU_INCR4  = 3'd3;
   localparam logic [2:0] BU_WRAP8  = 3'd4;
   localparam logic [2:0] BU_INCR8  = 3'd5;
   localparam logic [2:0] BU_WRAP16 = 3'd6;
   localparam logic [2:0] BU_INCR16 = 3'd7;

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_BUSY} state_t;

   state_t                state_q;
   logic [ADDR_WIDTH-1:0] haddr_q;
   logic [1:0]            htrans_q;
   logic [2:0]            hburst_q;
   logic [2:0]            hsize_q;
   logic                  hwrite_q;
   logic [LEN_WIDTH-1:0]  beat_idx_q;
   logic [LEN_WIDTH-1:0]  beats_q;
   logic                  done_q;
   logic                  err_q;

   // Command decode: beat count and legality of the offered command
   logic [LEN_WIDTH-1:0]  cmd_beats_c;
   logic [ADDR_WIDTH-1:0] size_mask_c;
   logic [ADDR_WIDTH:0]   start_ext_c;
   logic [ADDR_WIDTH:0]   last_ext_c;
   logic                  fixed_incr_c;
   logic                  cross_c;
   logic                  illegal_c;

   always_comb begin
      cmd_beats_c = LEN_WIDTH'(1);
      case (bus.cmd_burst)
         BU_SINGLE:          cmd_beats_c = LEN_WIDTH'(1);
         BU_INCR:            cmd_beats_c = (bus.cmd_len == '0) ? LEN_WIDTH'(1) : bus.cmd_len;
         BU_WRAP4, BU_INCR4: cmd_beats_c = LEN_WIDTH'(4);
         BU_WRAP8, BU_INCR8: cmd_beats_c = LEN_WIDTH'(8);
         default:            cmd_beats_c = LEN_WIDTH'(16);
      endcase
      size_mask_c  = (ADDR_WIDTH'(1) << bus.cmd_size) - ADDR_WIDTH'(1);
      start_ext_c  = {1'b0, bus.cmd_addr};
      // One extra bit so a burst running past the top of memory counts as crossing
      last_ext_c   = start_ext_c + (AW1'(cmd_beats_c) << bus.cmd_size) - AW1'(1);
      fixed_incr_c = (bus.cmd_burst == BU_INCR4) || (bus.cmd_burst == BU_INCR8) ||
                     (bus.cmd_burst == BU_INCR16);
      cross_c      = last_ext_c[ADDR_WIDTH:BND_W] != start_ext_c[ADDR_WIDTH:BND_W];
      illegal_c    = (bus.cmd_size > 3'(MAX_SIZE)) || ((bus.cmd_addr & size_mask_c) != '0) ||
                     (fixed_incr_c && cross_c);
   end

   // Next-beat address, beat bookkeeping and boundary detection
   logic [ADDR_WIDTH-1:0] step_c;
   logic [ADDR_WIDTH-1:0] incr_addr_c;
   logic [ADDR_WIDTH-1:0] wrap_mask_c;
   logic [ADDR_WIDTH-1:0] next_addr_c;
   logic                  is_wrap_c;
   logic                  next_bnd_c;
   logic                  cur_bnd_c;
   logic                  last_beat_c;
   logic [LEN_WIDTH-1:0]  idx_inc_c;

   always_comb begin
      step_c      = ADDR_WIDTH'(1) << hsize_q;
      incr_addr_c = haddr_q + step_c;
      wrap_mask_c = (ADDR_WIDTH'(beats_q) << hsize_q) - ADDR_WIDTH'(1);
      is_wrap_c   = (hburst_q == BU_WRAP4) || (hburst_q == BU_WRAP8) || (hburst_q == BU_WRAP16);
      next_addr_c = is_wrap_c ? ((haddr_q & ~wrap_mask_c) | (incr_addr_c & wrap_mask_c))
                              : incr_addr_c;
      // Undefined-length INCR restarts with NONSEQ at each boundary line
      next_bnd_c  = (hburst_q == BU_INCR) && (next_addr_c[BND_W-1:0] == '0);
      cur_bnd_c   = (hburst_q == BU_INCR) && (haddr_q[BND_W-1:0] == '0);
      last_beat_c = beat_idx_q == (beats_q - LEN_WIDTH'(1));
      idx_inc_c   = (&beat_idx_q) ? beat_idx_q : beat_idx_q + LEN_WIDTH'(1);
   end

   // Sequencer FSM with registered bus outputs
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q    <= S_IDLE;
         haddr_q    <= '0;
         htrans_q   <= TR_IDLE;
         hburst_q   <= BU_SINGLE;
         hsize_q    <= 3'd0;
         hwrite_q   <= 1'b0;
         beat_idx_q <= '0;
         beats_q    <= LEN_WIDTH'(1);
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.cmd_valid) begin
                  if (illegal_c) begin
                     err_q <= 1'b1;
                  end else begin
                     state_q    <= S_ACTIVE;
                     htrans_q   <= TR_NONSEQ;
                     haddr_q    <= bus.cmd_addr;
                     hburst_q   <= bus.cmd_burst;
                     hsize_q    <= bus.cmd_size;
                     hwrite_q   <= bus.cmd_write;
                     beat_idx_q <= '0;
                     beats_q    <= cmd_beats_c;
                  end
               end
            end
            S_ACTIVE: begin
               if (bus.HREADY) begin
                  if (last_beat_c) begin
                     done_q   <= 1'b1;
                     htrans_q <= TR_IDLE;
                     state_q  <= S_IDLE;
                  end else begin
                     haddr_q    <= next_addr_c;
                     beat_idx_q <= idx_inc_c;
                     if (bus.beat_stall) begin
                        state_q  <= S_BUSY;
                        htrans_q <= TR_BUSY;
                     end else begin
                        htrans_q <= next_bnd_c ? TR_NONSEQ : TR_SEQ;
                     end
                  end
               end
            end
            S_BUSY: begin
               // HADDR already points at the pending beat
               if (!bus.beat_stall && bus.HREADY) begin
                  state_q  <= S_ACTIVE;
                  htrans_q <= cur_bnd_c ? TR_NONSEQ : TR_SEQ;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.cmd_ready = (state_q == S_IDLE);
   assign bus.HADDR     = haddr_q;
   assign bus.HTRANS    = htrans_q;
   assign bus.HBURST    = hburst_q;
   assign bus.HSIZE     = hsize_q;
   assign bus.HWRITE    = hwrite_q;
   assign bus.beat_idx  = beat_idx_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
endmodule
